seqdiv_32by16: RTL and testbench

- Sequential unsigned restoring divider: 32-bit dividend by 16-bit divisor, giving a 16-bit quotient and a 16-bit remainder.
- Performs the inverse of the 16x16 approximate multiplier; used to recover or normalise products in the same arithmetic datapath.
- Valid/ready handshake on both sides, one radix-2 iteration per cycle.
- Optional approximate mode truncates low quotient bits, mirroring the multiplier's zeroed low product bits.

---
 rtl/seqdiv_pkg.sv | 19 +
 rtl/seqdiv_32by16_div_step.sv | 28 ++
 rtl/seqdiv_32by16.sv | 163 ++++++++++++++++
 tb/tb_seqdiv_32by16.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/seqdiv_pkg.sv
// Shared types and constants for the 32-by-16 sequential restoring divider.
// Optional build macro APPROX_TRUNC_EN is consumed by seqdiv_32by16.
package seqdiv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        RUN,
        DONE
    } state_t;

    localparam int DW_DEFAULT = 16;

    // Width of the iteration counter for a given datapath width.
    function automatic int iter_cnt_w(input int dw);
        return $clog2(dw + 1);
    endfunction

endpackage

// File: rtl/seqdiv_32by16_div_step.sv
// One combinational radix-2 restoring division iteration on the {R,Q} pair.
// R is held DW bits wide; the bit shifted out of it acts as the extra sign/carry bit.
module div_step
    import seqdiv_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic [DW-1:0] i_r,
    input  logic [DW-1:0] i_q,
    input  logic [DW-1:0] i_d,
    output logic [DW-1:0] o_r,
    output logic [DW-1:0] o_q
);

    logic          w_carry;
    logic [DW-1:0] w_sh;
    logic          w_ge;

    assign w_carry = i_r[DW-1];
    assign w_sh    = {i_r[DW-2:0], i_q[DW-1]};

    // A set carry means the shifted remainder is at least 2^DW > D, so the
    // subtraction always succeeds and its DW-bit modular result is exact.
    assign w_ge = w_carry | (w_sh >= i_d);
    assign o_r  = w_ge ? (w_sh - i_d) : w_sh;
    assign o_q  = {i_q[DW-2:0], w_ge};

endmodule

// File: rtl/seqdiv_32by16.sv
// Sequential unsigned restoring divider, 2*DW-bit dividend by DW-bit divisor.
// Define APPROX_TRUNC_EN to skip the low TRUNC_BITS quotient iterations.
module seqdiv_32by16
    import seqdiv_pkg::*;
#(
    parameter int DW         = DW_DEFAULT,
    parameter int TRUNC_BITS = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*DW-1:0] dividend,
    input  logic [DW-1:0]   divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   quotient,
    output logic [DW-1:0]   remainder,
    output logic            div_zero,
    output logic            overflow
);

    if (TRUNC_BITS < 0 || TRUNC_BITS >= DW) begin : g_bad_trunc
        $error("TRUNC_BITS must lie in 0..DW-1");
    end

`ifdef APPROX_TRUNC_EN
    localparam int SKIP = TRUNC_BITS;
`else
    localparam int SKIP = 0;
`endif
    localparam int            ITER      = DW - SKIP;
    localparam int            CW        = iter_cnt_w(DW);
    localparam logic [CW-1:0] LAST_ITER = CW'(ITER - 1);

    state_t          r_state;
    state_t          w_state_next;
    logic [2*DW-1:0] r_n;
    logic [DW-1:0]   r_d;
    logic [DW-1:0]   r_r;
    logic [DW-1:0]   r_q;
    logic [CW-1:0]   r_iter;
    logic [DW-1:0]   r_quot;
    logic [DW-1:0]   r_rem;
    logic            r_out_valid;
    logic            r_dz;
    logic            r_ovf;

    logic [DW-1:0]   w_n_hi;
    logic [DW-1:0]   w_n_lo;
    logic [DW-1:0]   w_r_next;
    logic [DW-1:0]   w_q_next;
    logic            w_dz;
    logic            w_ovf;
    logic            w_last;
    logic            w_accept;

    assign w_n_hi = r_n[2*DW-1:DW];
    assign w_n_lo = r_n[DW-1:0];
    assign w_dz   = (r_d == '0);
    assign w_ovf  = (w_n_hi >= r_d);
    assign w_last = (r_iter == LAST_ITER);

    div_step #(.DW(DW)) u_step (
        .i_r (r_r),
        .i_q (r_q),
        .i_d (r_d),
        .o_r (w_r_next),
        .o_q (w_q_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = CHECK;
                end
            end
            CHECK:   w_state_next = (w_dz || w_ovf) ? DONE : RUN;
            RUN:     if (w_last) w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_n         <= '0;
            r_d         <= '0;
            r_r         <= '0;
            r_q         <= '0;
            r_iter      <= '0;
            r_quot      <= '0;
            r_rem       <= '0;
            r_out_valid <= 1'b0;
            r_dz        <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_n <= dividend;
                r_d <= divisor;
            end
            case (r_state)
                CHECK: begin
                    if (w_dz) begin
                        r_dz        <= 1'b1;
                        r_quot      <= '1;
                        r_rem       <= w_n_lo;
                        r_out_valid <= 1'b1;
                    end else if (w_ovf) begin
                        r_ovf       <= 1'b1;
                        r_quot      <= '1;
                        r_rem       <= '0;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_r    <= w_n_hi;
                        r_q    <= w_n_lo;
                        r_iter <= '0;
                    end
                end
                RUN: begin
                    r_r    <= w_r_next;
                    r_q    <= w_q_next;
                    r_iter <= r_iter + 1'b1;
                    if (w_last) begin
                        // Left-justify so skipped quotient bits read as zero.
                        r_quot      <= w_q_next << SKIP;
                        r_rem       <= w_r_next;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_dz        <= 1'b0;
                        r_ovf       <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign quotient  = r_quot;
    assign remainder = r_rem;
    assign div_zero  = r_dz;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_seqdiv_32by16.sv
// Self-checking bench for seqdiv_32by16: directed cases plus randomized operands
// checked against an arithmetic reference model (honours APPROX_TRUNC_EN).
module tb_seqdiv_32by16;

    localparam int DW    = 16;
    localparam int TRUNC = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_zero;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seqdiv_32by16 #(.DW(DW), .TRUNC_BITS(TRUNC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .overflow  (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division, with latency taken from the cycle budget rules.
    task automatic model(input logic [31:0] n, input logic [15:0] d,
                         output logic [15:0] q, output logic [15:0] r,
                         output logic dz, output logic ov, output int lat);
        logic [31:0] full;
        dz = 1'b0;
        ov = 1'b0;
        if (d == 16'd0) begin
            dz  = 1'b1;
            q   = 16'hFFFF;
            r   = n[15:0];
            lat = 2;
        end else begin
            full = n / {16'd0, d};
            if (full > 32'h0000_FFFF) begin
                ov  = 1'b1;
                q   = 16'hFFFF;
                r   = 16'h0000;
                lat = 2;
            end else begin
`ifdef APPROX_TRUNC_EN
                q   = 16'((full >> TRUNC) << TRUNC);
                r   = 16'((n >> TRUNC) % {16'd0, d});
                lat = DW - TRUNC + 2;
`else
                q   = full[15:0];
                r   = 16'(n % {16'd0, d});
                lat = DW + 2;
`endif
            end
        end
    endtask

    task automatic do_op(input logic [31:0] n, input logic [15:0] d, input int hold);
        logic [15:0] eq, er, sq, sr;
        logic        edz, eov, sdz, sov;
        logic        busy_ok, stable_ok;
        int          elat, lat;
        model(n, d, eq, er, edz, eov, elat);
        @(negedge clk);
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        dividend = n;
        divisor  = d;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = 16'($urandom);
        busy_ok  = 1'b1;
        while (out_valid !== 1'b1 && lat < 200) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (in_ready !== 1'b0) busy_ok = 1'b0;
        chk("latency", lat, elat);
        sq = quotient; sr = remainder; sdz = div_zero; sov = overflow;
        stable_ok = 1'b1;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid !== 1'b1 || quotient !== sq || remainder !== sr ||
                div_zero !== sdz || overflow !== sov || in_ready !== 1'b0)
                stable_ok = 1'b0;
        end
        chk("busy_in_ready", {31'd0, busy_ok}, 32'd1);
        chk("hold_stable", {31'd0, stable_ok}, 32'd1);
        chk("quotient", {16'd0, quotient}, {16'd0, eq});
        chk("remainder", {16'd0, remainder}, {16'd0, er});
        chk("div_zero", {31'd0, div_zero}, {31'd0, edz});
        chk("overflow", {31'd0, overflow}, {31'd0, eov});
        $display("op n=%h d=%h q=%h r=%h dz=%0d ov=%0d lat=%0d hold=%0d",
                 n, d, quotient, remainder, div_zero, overflow, lat, hold);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_clear", {31'd0, out_valid}, 32'd0);
        chk("in_ready_after", {31'd0, in_ready}, 32'd1);
        chk("flags_clear", {30'd0, div_zero, overflow}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] n;
        logic [15:0] d;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_q_r", {quotient, remainder}, 32'd0);
        chk("rst_flags", {30'd0, div_zero, overflow}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        do_op(32'h0000_0064, 16'h0007, 0);
        do_op(32'h1234_5678, 16'h0000, 1);
        do_op(32'h0010_0000, 16'h0010, 0);
        do_op(32'hFFFE_0001, 16'hFFFF, 5);

        // Reset in the middle of an exact-mode run.
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 32'h0000_0064;
        divisor  = 16'h0007;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_q_r", {quotient, remainder}, 32'd0);
        chk("midrst_flags", {30'd0, div_zero, overflow}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        chk("midrst_idle_valid", {31'd0, out_valid}, 32'd0);
        do_op(32'h0000_0009, 16'h0003, 0);

        for (int i = 0; i < 24; i++) begin
            case (i % 4)
                0: begin
                    d = 16'($urandom_range(1, 65535));
                    n = {16'($urandom % {16'd0, d}), 16'($urandom)};
                end
                1: begin
                    d = 16'($urandom_range(1, 15));
                    n = {16'($urandom % {16'd0, d}), 16'($urandom)};
                end
                2: begin
                    d = 16'($urandom);
                    n = $urandom;
                end
                default: begin
                    d = (i % 8 == 3) ? 16'd0 : 16'hFFFF;
                    n = $urandom;
                end
            endcase
            do_op(n, d, int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
